// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - MEM-stage request/response and dmemory port bundle for dmem_lsu
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport master (
    input  req_valid, req_addr, req_we, req_funct3, req_wdata, resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_address, mem_read_write, mem_access_size, mem_data_in
  );

  modport slave (
    output req_valid, req_addr, req_we, req_funct3, req_wdata, resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_address, mem_read_write, mem_access_size, mem_data_in
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit: decodes and checks one MEM-stage access, drives dmemory,
// returns extended load data or a fault code
module dmem_lsu #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0010_0000,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_lsu_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [3:0]  lat_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  fault_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] din_q;

  logic [1:0]  dec_size;
  logic        dec_legal;
  logic        dec_misal;
  logic        dec_oor;
  logic [32:0] dec_first;
  logic [32:0] dec_last;
  logic [32:0] mem_end;
  logic [1:0]  dec_fault;
  logic [31:0] dec_din;
  logic [31:0] load_ext;

  // Range check is done in 33 bits so a request near 0xFFFF_FFFF cannot wrap into range.
  always_comb begin
    dec_size  = bus.req_funct3[1:0];
    dec_legal = 1'b0;
    dec_fault = 2'b00;
    dec_din   = bus.req_wdata;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: dec_legal = 1'b1;
      3'b100, 3'b101:         dec_legal = ~bus.req_we;
      default:                dec_legal = 1'b0;
    endcase
    dec_misal = ((dec_size == 2'd1) && bus.req_addr[0]) ||
                ((dec_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    dec_first = {1'b0, bus.req_addr};
    dec_last  = dec_first + (33'd1 << dec_size) - 33'd1;
    mem_end   = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};
    dec_oor   = (dec_first < {1'b0, BASE_ADDR}) || (dec_last >= mem_end);
    if (!dec_legal)     dec_fault = 2'b01;
    else if (dec_misal) dec_fault = 2'b10;
    else if (dec_oor)   dec_fault = 2'b11;
    case (dec_size)
      2'd0:    dec_din = {24'b0, bus.req_wdata[7:0]};
      2'd1:    dec_din = {16'b0, bus.req_wdata[15:0]};
      default: dec_din = bus.req_wdata;
    endcase
  end

  always_comb begin
    load_ext = bus.mem_data_out;
    case (f3_q)
      3'b000:  load_ext = {{24{bus.mem_data_out[7]}}, bus.mem_data_out[7:0]};
      3'b001:  load_ext = {{16{bus.mem_data_out[15]}}, bus.mem_data_out[15:0]};
      3'b100:  load_ext = {24'b0, bus.mem_data_out[7:0]};
      3'b101:  load_ext = {16'b0, bus.mem_data_out[15:0]};
      default: load_ext = bus.mem_data_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = (dec_fault != 2'b00) ? RESP : ACCESS;
      ACCESS:  if (we_q || (lat_cnt == 4'd1)) state_nx = RESP;
      RESP:    if (bus.resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A faulting request only updates the response registers; mem_* keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      lat_cnt <= 4'd0;
      rdata_q <= 32'd0;
      fault_q <= 2'b00;
      addr_q  <= BASE_ADDR;
      size_q  <= 2'd2;
      din_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            lat_cnt <= 4'(MEM_LAT);
            rdata_q <= 32'd0;
            fault_q <= dec_fault;
            if (dec_fault == 2'b00) begin
              addr_q <= bus.req_addr;
              size_q <= dec_size;
              din_q  <= dec_din;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) rdata_q <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready       = (state == IDLE);
  assign bus.resp_valid      = (state == RESP);
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_fault      = fault_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_read_write  = (state == ACCESS) && we_q;
  assign bus.mem_access_size = size_q;
  assign bus.mem_data_in     = din_q;
endmodule
